// File: rtl/clock_gen_pkg.sv
// Shared encodings and defaults for the multi-channel audio clock generator.
package clock_gen_pkg;

    typedef enum logic [1:0] {
        SEL_64K    = 2'b00,
        SEL_15K    = 2'b01,
        SEL_MASTER = 2'b10,
        SEL_OFF    = 2'b11
    } ch_sel_e;

    localparam int unsigned DIV64_DEF = 28;
    localparam int unsigned DIV15_DEF = 114;
    localparam int unsigned MIN_DIV   = 2;

endpackage

// File: rtl/tick_divider.sv
// Binary down-counter that emits a one-clk tick every `divisor` enn strobes.
module tick_divider
    import clock_gen_pkg::*;
#(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RST_DIV = DIV64_DEF
) (
    input  logic           clk,
    input  logic           init,
    input  logic           enn,
    input  logic [CNT_W:0] divisor,
    output logic           tick
);

    logic [CNT_W-1:0] count;

    // Reset reloads from RST_DIV, not from divisor, since a runtime divisor
    // register is being restored on the same edge.
    always_ff @(negedge clk) begin
        if (init) begin
            count <= CNT_W'(RST_DIV - 1);
            tick  <= 1'b0;
        end else if (enn) begin
            if (count == '0) begin
                count <= CNT_W'(divisor - (CNT_W + 1)'(1));
                tick  <= 1'b1;
            end else begin
                count <= count - CNT_W'(1);
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/clock_gen_multi.sv
// Multi-channel audio clock generator: 64k/15k dividers, per-channel source mux,
// keyboard scan clock. Optional runtime divisors under `CLKGEN_RATE_LOAD_EN`.
module clock_gen_multi
    import clock_gen_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 8,
    parameter int unsigned DIV64  = DIV64_DEF,
    parameter int unsigned DIV15  = DIV15_DEF
) (
    input  logic                  clk,
    input  logic                  init,
    input  logic                  enn,
    input  logic [2*NUM_CH-1:0]   ch_sel,
    output logic [NUM_CH-1:0]     aud_clk,
    output logic                  tick64,
    output logic                  tick15,
    output logic                  keyb_clk
`ifdef CLKGEN_RATE_LOAD_EN
    ,
    input  logic                  div_load,
    input  logic [CNT_W-1:0]      div64_in,
    input  logic [CNT_W-1:0]      div15_in
`endif
);

    logic [CNT_W:0]    div64_r;
    logic [CNT_W:0]    div15_r;
    logic              enn_d;
    logic [NUM_CH-1:0] aud_next;

`ifdef CLKGEN_RATE_LOAD_EN
    function automatic logic [CNT_W:0] clamp_div(input logic [CNT_W-1:0] d);
        if ({1'b0, d} < (CNT_W + 1)'(MIN_DIV))
            return (CNT_W + 1)'(MIN_DIV);
        return {1'b0, d};
    endfunction

    // New divisors only reach the counters at their next wrap reload.
    always_ff @(negedge clk) begin
        if (init) begin
            div64_r <= (CNT_W + 1)'(DIV64);
            div15_r <= (CNT_W + 1)'(DIV15);
        end else if (div_load) begin
            div64_r <= clamp_div(div64_in);
            div15_r <= clamp_div(div15_in);
        end
    end
`else
    assign div64_r = (CNT_W + 1)'(DIV64);
    assign div15_r = (CNT_W + 1)'(DIV15);
`endif

    tick_divider #(
        .CNT_W   (CNT_W),
        .RST_DIV (DIV64)
    ) u_div64 (
        .clk     (clk),
        .init    (init),
        .enn     (enn),
        .divisor (div64_r),
        .tick    (tick64)
    );

    tick_divider #(
        .CNT_W   (CNT_W),
        .RST_DIV (DIV15)
    ) u_div15 (
        .clk     (clk),
        .init    (init),
        .enn     (enn),
        .divisor (div15_r),
        .tick    (tick15)
    );

    // Delaying enn one clk puts the master source on the same cycle as the ticks.
    always_ff @(negedge clk) begin
        if (init)
            enn_d <= 1'b0;
        else
            enn_d <= enn;
    end

    always_comb begin
        aud_next = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            unique case (ch_sel_e'(ch_sel[2*c +: 2]))
                SEL_64K:    aud_next[c] = tick64;
                SEL_15K:    aud_next[c] = tick15;
                SEL_MASTER: aud_next[c] = enn_d;
                default:    aud_next[c] = 1'b0;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (init)
            aud_clk <= '0;
        else
            aud_clk <= aud_next;
    end

    assign keyb_clk = ~tick15;

endmodule

// File: tb/tb_clock_gen_multi.sv
// Scoreboard bench for clock_gen_multi: randomized enn/ch_sel/init against a strobe-counting model.
module tb_clock_gen_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int DIV64  = 28;
    localparam int DIV15  = 114;

    logic              clk = 1'b0;
    logic              init = 1'b1;
    logic              enn = 1'b0;
    logic [2*NUM_CH-1:0] ch_sel = '0;
    logic [NUM_CH-1:0] aud_clk;
    logic              tick64, tick15, keyb_clk;
`ifdef CLKGEN_RATE_LOAD_EN
    logic              div_load = 1'b0;
    logic [CNT_W-1:0]  div64_in = '0;
    logic [CNT_W-1:0]  div15_in = '0;
`endif

    clock_gen_multi #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DIV64  (DIV64),
        .DIV15  (DIV15)
    ) dut (
        .clk      (clk),
        .init     (init),
        .enn      (enn),
        .ch_sel   (ch_sel),
        .aud_clk  (aud_clk),
        .tick64   (tick64),
        .tick15   (tick15),
        .keyb_clk (keyb_clk)
`ifdef CLKGEN_RATE_LOAD_EN
        ,
        .div_load (div_load),
        .div64_in (div64_in),
        .div15_in (div15_in)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] aud;
        logic              t64;
        logic              t15;
        logic              kb;
        int                cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Model: count enn strobes since the last wrap; wrap when the count reaches the
    // period in force; a wrap adopts the divisor register as the next period.
    int p64, p15, per64, per15, reg64, reg15;
    bit m_t64, m_t15, m_ennd;
    bit [NUM_CH-1:0] m_aud;

    task automatic drive(input bit i, input bit e, input logic [2*NUM_CH-1:0] s,
                         input bit ld, input int d64, input int d15);
        exp_t x;
        bit [NUM_CH-1:0] aud_n;
        bit t64_n, t15_n;
        @(posedge clk);
        init = i; enn = e; ch_sel = s;
`ifdef CLKGEN_RATE_LOAD_EN
        div_load = ld; div64_in = CNT_W'(d64); div15_in = CNT_W'(d15);
`endif
        cyc++;
        if (i) begin
            p64 = 0; p15 = 0; per64 = DIV64; per15 = DIV15; reg64 = DIV64; reg15 = DIV15;
            m_t64 = 0; m_t15 = 0; m_ennd = 0; m_aud = '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                case (s[2*c +: 2])
                    2'b00:   aud_n[c] = m_t64;
                    2'b01:   aud_n[c] = m_t15;
                    2'b10:   aud_n[c] = m_ennd;
                    default: aud_n[c] = 1'b0;
                endcase
            end
            t64_n = 0; t15_n = 0;
            if (e) begin
                p64++; p15++;
                if (p64 == per64) begin t64_n = 1; p64 = 0; per64 = reg64; end
                if (p15 == per15) begin t15_n = 1; p15 = 0; per15 = reg15; end
            end
`ifdef CLKGEN_RATE_LOAD_EN
            if (ld) begin
                reg64 = (d64 < 2) ? 2 : d64;
                reg15 = (d15 < 2) ? 2 : d15;
            end
`endif
            m_aud = aud_n; m_t64 = t64_n; m_t15 = t15_n; m_ennd = e;
        end
        x.aud = m_aud; x.t64 = m_t64; x.t15 = m_t15; x.kb = ~m_t15; x.cyc = cyc;
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                checks += 4;
                if (aud_clk !== x.aud) begin
                    failures++;
                    $display("FAIL aud_clk cyc=%0d got=%b exp=%b", x.cyc, aud_clk, x.aud);
                end
                if (tick64 !== x.t64) begin
                    failures++;
                    $display("FAIL tick64 cyc=%0d got=%b exp=%b", x.cyc, tick64, x.t64);
                end
                if (tick15 !== x.t15) begin
                    failures++;
                    $display("FAIL tick15 cyc=%0d got=%b exp=%b", x.cyc, tick15, x.t15);
                end
                if (keyb_clk !== x.kb) begin
                    failures++;
                    $display("FAIL keyb_clk cyc=%0d got=%b exp=%b", x.cyc, keyb_clk, x.kb);
                end
            end
        end
    end

    initial begin : stimulus
        logic [2*NUM_CH-1:0] sel;
        bit e, i, ld;
        int d64, d15;
        sel = 8'b01_00_10_11;
        repeat (3) drive(1, 1, sel, 0, 0, 0);
        // continuous enn: first ticks 28 and 114 clks after release
        repeat (300) drive(0, 1, sel, 0, 0, 0);
        // enn every 2nd clk
        for (int k = 0; k < 300; k++) drive(0, k[0], sel, 0, 0, 0);
        // init mid-count
        repeat (17) drive(0, 1, sel, 0, 0, 0);
        drive(1, 1, sel, 0, 0, 0);
        repeat (150) drive(0, 1, sel, 0, 0, 0);
`ifdef CLKGEN_RATE_LOAD_EN
        drive(1, 0, sel, 0, 0, 0);
        repeat (10) drive(0, 1, sel, 0, 0, 0);
        drive(0, 1, sel, 1, 4, 200);
        repeat (60) drive(0, 1, sel, 0, 0, 0);
        drive(0, 1, sel, 1, 1, 0);
        repeat (20) drive(0, 1, sel, 0, 0, 0);
        drive(1, 1, sel, 1, 5, 5);
        repeat (150) drive(0, 1, sel, 0, 0, 0);
`endif
        // randomized traffic
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(19) == 0) sel = (2*NUM_CH)'($urandom);
            e  = ($urandom_range(3) != 0);
            i  = ($urandom_range(399) == 0);
            ld = ($urandom_range(99) == 0);
            d64 = $urandom_range(40);
            d15 = $urandom_range(150);
            drive(i, e, sel, ld, d64, d15);
        end
        drive(0, 0, sel, 0, 0, 0);
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d exp=0", q.size());
        end
        checks++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
